seq_sched: RTL and testbench
============================

# seq_sched

Round-robin scheduler that shares one serial pair-detector among `NREQ` requesters. Each requester presents a `WIDTH`-bit word. The block grants one requester at a time, shifts the winner's word MSB-first into the shared Moore detector, and returns the number of adjacent equal-bit pairs it found along with the requester ID. It sits in front of the serial sequence-detection datapath and is the only path into it.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: word length in bits, 2..16.
- `CNTW`, default `$clog2(WIDTH)`: width of `match_cnt`. It must hold WIDTH-1.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req`, in, NREQ: level request per requester.
- `data`, in, NREQ*WIDTH: word of requester i at `[i*WIDTH +: WIDTH]`.
- `gnt`, out, NREQ: one-hot grant, high for exactly one cycle.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle result strobe.
- `done_id`, out, $clog2(NREQ): requester that owns the result.
- `match_cnt`, out, CNTW: number of adjacent equal pairs in the word.

## Operation
- The FSM has five states: IDLE, LOAD, SHIFT, DRAIN, DONE.
- **IDLE**: if any `req` bit is set at the edge, pick the winner by round-robin and move to LOAD. Otherwise stay in IDLE.
- **Round-robin**: search starts at `last+1` mod NREQ. `last` is updated to the winner. `last` resets to NREQ-1, so requester 0 has first priority after reset.
- **LOAD**: `gnt[winner]`=1. At the end of LOAD:
  - the shift register captures `data[winner]`;
  - the bit counter is cleared;
  - the detector is cleared;
  - the FSM moves to SHIFT.
- **SHIFT**: lasts WIDTH cycles. Each cycle presents one bit, MSB first, to the detector.
- **DRAIN**: lasts one cycle. The Moore output for the last bit is accumulated here.
- **DONE**: `done`=1, `done_id`=winner, `match_cnt` is final. Next state is IDLE.
- **Detector**: it is cleared per word, so pairs never span two words. A pair counts at bit k (k ≥ 1) when `bit[k]==bit[k-1]`. Result range is 0..WIDTH-1.
- **Requester obligations**:
  - Hold `req` and `data` stable until `gnt` is seen.
  - `data` is don't-care after LOAD.
  - `req` still high in the cycle after `gnt` means a new word, which is re-arbitrated fairly.
- Deasserting `req` during SHIFT has no effect on the word in flight.
- `done_id` and `match_cnt` hold their last value between `done` pulses.
- **Reset, from any state**:
  - Outputs: `gnt`=0, `busy`=0, `done`=0, `done_id`=0, `match_cnt`=0.
  - Internal: FSM=IDLE, `last`=NREQ-1, detector cleared.
  - A word in flight is abandoned with no `done`. The requester must request again.

## Timing
- Let E0 be the edge where IDLE samples `req`. Counting the LOAD cycle as cycle 1:
  - LOAD (`gnt`): cycle 1.
  - SHIFT: cycles 2..WIDTH+1.
  - DRAIN: cycle WIDTH+2.
  - DONE: cycle WIDTH+3.
  - IDLE: cycle WIDTH+4.
- With WIDTH=8: `gnt` in cycle 1, `done` in cycle 11, minimum grant-to-grant spacing 12 cycles.
- All outputs are registered. There is no combinational path from `req` or `data` to any output.
- `busy` rises together with `gnt` and falls in the cycle after `done`.

## Structure
- Package `seq_sched_pkg` holds:
  - the state encoding `sched_state_t` (IDLE, LOAD, SHIFT, DRAIN, DONE);
  - the detector state type `pd_state_t` (four 2-bit states);
  - any shared width helper constants.
- Sub-module `pair_detect` (ports: `clk`, `reset_n`, `clr`, `bit_valid`, `bit_in`, `hit`):
  - four-state Moore machine;
  - `hit` is decoded from state only;
  - `clr` forces the start state synchronously.
- `seq_sched` holds:
  - the arbiter;
  - the FSM;
  - the WIDTH-bit shift register;
  - the bit counter;
  - the CNTW-bit match accumulator;
  - one instance of `pair_detect`.

## Test plan
- **Single requester**: `req[2]` held with `data[2]`=8'b10110011. Expect `gnt`=4'b0100 in cycle 1, then `done` in cycle 11 with `done_id`=2 and `match_cnt`=3.
- **Extremes**: 8'hFF gives 7, 8'h00 gives 7, 8'h55 gives 0, 8'hF0 gives 6.
- **Fairness**: after reset, hold `req`=4'b1111 for four words. Grant order is 0, 1, 2, 3, then 0. Grants are spaced exactly 12 cycles apart.
- **Late request**: `req[3]` rises during requester 1's SHIFT. It is granted in the cycle after requester 1's IDLE sample, with no starvation.
- **Reset mid-word**: drop `reset_n` in SHIFT cycle 5. All outputs go 0 immediately, no `done` follows, and the next grant goes to requester 0.
- **Stability**: change `data[i]` to 8'h00 during SHIFT for the active requester. The result still matches the word captured at LOAD.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared types and helpers for the round-robin pair-detect scheduler.
package seq_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  // Detector states: bit 1 is the last bit seen, bit 0 flags that it
  // equalled the bit before it. PD_L0 is the start state after a clear.
  typedef enum logic [1:0] {
    PD_L0      = 2'b00,
    PD_L0_PAIR = 2'b01,
    PD_L1      = 2'b10,
    PD_L1_PAIR = 2'b11
  } pd_state_t;

  // Bounds of the supported configuration.
  localparam int unsigned NREQ_MAX  = 8;
  localparam int unsigned WIDTH_MAX = 16;

  // Next detector state after consuming one bit.
  function automatic pd_state_t pd_next(input pd_state_t cur, input logic b);
    logic [1:0] cur_bits;
    cur_bits = cur;
    return pd_state_t'({b, (b == cur_bits[1])});
  endfunction

  // Moore output: a pair was completed by the last consumed bit.
  function automatic logic pd_hit(input pd_state_t cur);
    logic [1:0] cur_bits;
    cur_bits = cur;
    return cur_bits[0];
  endfunction

endpackage

// File: rtl/seq_sched_pair_detect.sv
// Four-state Moore detector for adjacent equal bits in a serial stream.
module pair_detect
  import seq_sched_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic hit
);

  pd_state_t state_r;
  pd_state_t state_s;

  // Next state: clear wins over a valid bit, otherwise hold.
  always_comb begin
    state_s = state_r;
    if (clr) begin
      state_s = PD_L0;
    end else if (bit_valid) begin
      state_s = pd_next(state_r, bit_in);
    end else begin
      state_s = state_r;
    end
  end

  // Detector state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= PD_L0;
    end else begin
      state_r <= state_s;
    end
  end

  assign hit = pd_hit(state_r);

endmodule

// File: rtl/seq_sched.sv
// Round-robin scheduler feeding requester words MSB-first into one shared
// pair detector and reporting the pair count with the owner ID.
module seq_sched
  import seq_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [CNTW-1:0]       match_cnt
);

  localparam int IDW = $clog2(NREQ);
  localparam int BCW = $clog2(WIDTH);

  sched_state_t     state_r;
  sched_state_t     state_s;
  logic [IDW-1:0]   last_r;
  logic [IDW-1:0]   win_r;
  logic [IDW-1:0]   win_s;
  logic             any_req_s;
  logic [NREQ-1:0]  gnt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [BCW-1:0]   bcnt_r;
  logic [CNTW-1:0]  acc_r;
  logic             pd_clr_s;
  logic             pd_valid_s;
  logic             pd_hit_s;

  assign any_req_s  = |req;
  assign pd_clr_s   = (state_r == ST_LOAD);
  assign pd_valid_s = (state_r == ST_SHIFT);

  // Round-robin pick: first requester at or after last+1, wrapping.
  always_comb begin
    int   idx;
    logic found;
    win_s = last_r;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_r) + i) % NREQ;
      if (!found && req[idx]) begin
        win_s = IDW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Next state and next values of the registered strobes.
  always_comb begin
    state_s = state_r;
    gnt_s   = {NREQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_LOAD;
          gnt_s   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD:  state_s = ST_SHIFT;
      ST_SHIFT: begin
        if (bcnt_r == BCW'(WIDTH - 1)) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DRAIN: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // FSM register plus grant/busy/done output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      gnt     <= {NREQ{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      gnt     <= gnt_s;
      busy    <= (state_s != ST_IDLE);
      done    <= (state_s == ST_DONE);
    end
  end

  // Arbiter memory, shift register, bit counter, accumulator and results.
  // The detector output seen at bit counter 1 reflects only the first bit
  // against the cleared start state, so accumulation begins at counter 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_r    <= IDW'(NREQ - 1);
      win_r     <= {IDW{1'b0}};
      shreg_r   <= {WIDTH{1'b0}};
      bcnt_r    <= {BCW{1'b0}};
      acc_r     <= {CNTW{1'b0}};
      done_id   <= {IDW{1'b0}};
      match_cnt <= {CNTW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            win_r  <= win_s;
            last_r <= win_s;
          end else begin
            win_r  <= win_r;
          end
        end
        ST_LOAD: begin
          shreg_r <= data[int'(win_r) * WIDTH +: WIDTH];
          bcnt_r  <= {BCW{1'b0}};
          acc_r   <= {CNTW{1'b0}};
        end
        ST_SHIFT: begin
          shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
          bcnt_r  <= bcnt_r + BCW'(1);
          if ((int'(bcnt_r) >= 2) && pd_hit_s) begin
            acc_r <= acc_r + CNTW'(1);
          end else begin
            acc_r <= acc_r;
          end
        end
        ST_DRAIN: begin
          match_cnt <= acc_r + CNTW'(pd_hit_s);
          done_id   <= win_r;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  pair_detect u_pair_detect (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (pd_clr_s),
    .bit_valid (pd_valid_s),
    .bit_in    (shreg_r[WIDTH-1]),
    .hit       (pd_hit_s)
  );

endmodule

// File: tb/tb_seq_sched.sv
// Self-checking bench for seq_sched: transaction-level model plus directed tests.
module tb_seq_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int CNTW = 3;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] data = '0;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [CNTW-1:0]   match_cnt;

  int total = 0;
  int bad   = 0;
  int cycnt = 0;
  logic chk_en = 1'b0;

  seq_sched #(.NREQ(NREQ), .WIDTH(W), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time grants and results.
  always @(posedge clk) cycnt <= cycnt + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pairs(input logic [W-1:0] w);
    int n = 0;
    for (int k = 1; k < W; k++) if (w[k] == w[k-1]) n++;
    return n;
  endfunction

  // ---------------- behavioural model ----------------
  int              m_last;
  logic            m_active;
  int              m_age;
  int              m_id;
  logic [W-1:0]    m_word;
  logic [NREQ-1:0] e_gnt;
  logic            e_busy, e_done;
  int              e_id, e_cnt;

  // Model: one word occupies WIDTH+3 cycles from grant to done.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0; m_last = NREQ - 1; m_age = 0; m_id = 0; m_word = '0;
      e_gnt = '0; e_busy = 1'b0; e_done = 1'b0; e_id = 0; e_cnt = 0;
    end else begin
      e_gnt  = '0;
      e_done = 1'b0;
      if (!m_active) begin
        if (req != '0) begin
          for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (!m_active && req[idx]) begin
              m_active = 1'b1; m_id = idx;
            end
          end
          m_last = m_id;
          m_age  = 1;
          e_gnt  = 4'(1 << m_id);
          e_busy = 1'b1;
        end else begin
          e_busy = 1'b0;
        end
      end else begin
        if (m_age == 1) m_word = data[m_id*W +: W];
        m_age++;
        if (m_age == W + 3) begin
          e_done = 1'b1; e_id = m_id; e_cnt = pairs(m_word);
        end
        if (m_age == W + 4) begin
          m_active = 1'b0; e_busy = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_gnt", longint'(gnt), longint'(e_gnt));
      chk("cyc_busy", longint'(busy), longint'(e_busy));
      chk("cyc_done", longint'(done), longint'(e_done));
      chk("cyc_done_id", longint'(done_id), longint'(e_id));
      chk("cyc_match_cnt", longint'(match_cnt), longint'(e_cnt));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_gnt(input string name, output int t, output logic [NREQ-1:0] g);
    logic found = 1'b0;
    t = -1; g = '0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (gnt != '0) begin found = 1'b1; t = cycnt; g = gnt; end
    end
    if (!found) chk({name, "_gnt_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name, output int t, output int id, output int cnt);
    logic found = 1'b0;
    t = -1; id = -1; cnt = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (done) begin found = 1'b1; t = cycnt; id = int'(done_id); cnt = int'(match_cnt); end
    end
    if (!found) chk({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    if (!found) chk({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic single(input string name, input int id, input logic [W-1:0] w, input int exp);
    int n, t, did, mc;
    logic [NREQ-1:0] g;
    @(posedge clk); #1;
    req = '0; req[id] = 1'b1; data[id*W +: W] = w; n = cycnt;
    wait_gnt(name, t, g);
    chk({name, "_gnt_vec"}, longint'(g), longint'(1 << id));
    chk({name, "_gnt_cycle"}, t - n, 1);
    @(posedge clk); #1;
    req[id] = 1'b0;
    wait_done(name, t, did, mc);
    chk({name, "_done_cycle"}, t - n, W + 3);
    chk({name, "_done_id"}, did, id);
    chk({name, "_match_cnt"}, mc, exp);
    wait_idle(name);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n, t, tp, did, mc;
    logic [NREQ-1:0] g;

    // Pin the model's pair counter with hand-computed values.
    chk("model_b3", pairs(8'b10110011), 3);
    chk("model_ff", pairs(8'hFF), 7);
    chk("model_00", pairs(8'h00), 7);
    chk("model_55", pairs(8'h55), 0);
    chk("model_f0", pairs(8'hF0), 6);

    #2 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", longint'(gnt), 0);
    chk("rst_busy", longint'(busy), 0);
    #2 reset_n = 1'b1;

    // Fairness: all four request; grants 0,1,2,3,0 spaced 12 cycles.
    @(posedge clk); #1;
    data = {8'hF0, 8'h55, 8'h00, 8'hFF};
    req  = 4'b1111; n = cycnt; tp = n;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("fair", t, g);
      chk("fair_order", longint'(g), longint'(1 << (k % 4)));
      if (k == 0) chk("fair_first_cycle", t - n, 1);
      else        chk("fair_spacing", t - tp, 12);
      tp = t;
    end
    @(posedge clk); #1;
    req = '0;
    wait_done("fair", t, did, mc);
    chk("fair_last_id", did, 0);
    chk("fair_last_cnt", mc, 7);
    wait_idle("fair");

    // Single requester and data extremes.
    single("single", 2, 8'b10110011, 3);
    single("ext_ff", 0, 8'hFF, 7);
    single("ext_00", 1, 8'h00, 7);
    single("ext_55", 3, 8'h55, 0);
    single("ext_f0", 2, 8'hF0, 6);

    // Late request: req[3] rises during requester 1's SHIFT.
    @(posedge clk); #1;
    req = 4'b0010; data[15:8] = 8'hAA;
    wait_gnt("late1", t, g);
    chk("late1_gnt", longint'(g), 2);
    repeat (3) @(posedge clk);
    #1;
    req[3] = 1'b1; data[31:24] = 8'h0F;
    tp = t;
    wait_gnt("late3", t, g);
    chk("late3_gnt", longint'(g), 8);
    chk("late3_spacing", t - tp, 12);
    @(posedge clk); #1;
    req = '0;
    wait_done("late3", t, did, mc);
    chk("late3_done_id", did, 3);
    chk("late3_cnt", mc, 6);
    wait_idle("late3");

    // Stability: data of the active requester changes during SHIFT.
    @(posedge clk); #1;
    req = 4'b0010; data[15:8] = 8'b10110011;
    wait_gnt("stab", t, g);
    @(posedge clk); #1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    data[15:8] = 8'h00;
    wait_done("stab", t, did, mc);
    chk("stab_done_id", did, 1);
    chk("stab_cnt", mc, 3);
    wait_idle("stab");

    // Reset in SHIFT cycle 5: outputs clear at once, no done, next grant to 0.
    @(posedge clk); #1;
    req = 4'b0100; data[23:16] = 8'hFF;
    wait_gnt("rmid", t, g);
    @(posedge clk); #1;
    req = '0;
    repeat (5) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rmid_gnt", longint'(gnt), 0);
    chk("rmid_busy", longint'(busy), 0);
    chk("rmid_done", longint'(done), 0);
    chk("rmid_done_id", longint'(done_id), 0);
    chk("rmid_match_cnt", longint'(match_cnt), 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    req = 4'b1111;
    wait_gnt("rmid_next", t, g);
    chk("rmid_next_gnt", longint'(g), 1);
    @(posedge clk); #1;
    req = '0;
    wait_done("rmid_next", t, did, mc);
    chk("rmid_next_id", did, 0);
    wait_idle("rmid_next");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
